// File: rtl/dff_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_sync_pkg
// Description : Shared defaults and reset polarity for the dff_sync register.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_sync_pkg;

    localparam int   DEF_WIDTH   = 1;
    localparam int   DEF_STAGES  = 1;
    localparam int   DEF_RST_VAL = 0;
    localparam logic RST_ACTIVE  = 1'b1;

endpackage : dff_sync_pkg
`default_nettype wire

// File: rtl/dff_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : dff_sync_if
// Description : Data/enable bundle of the dff_sync register (D/en in, Q/Q_n out).
// Revision    : 1.0 - initial release
// ============================================================================
interface dff_sync_if
    import dff_sync_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_n;

    modport master (
        output en,
        output D,
        input  Q,
        input  Q_n
    );

    modport slave (
        input  en,
        input  D,
        output Q,
        output Q_n
    );

endinterface : dff_sync_if
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// ============================================================================
// Module      : dff_stage
// Description : Single enabled register with synchronous reset to RST_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_stage
    import dff_sync_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter     RST_VAL = DEF_RST_VAL
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    // Reset value is truncated or zero-extended to the data width.
    localparam logic [WIDTH-1:0] C_RST_VAL = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            r_q <= C_RST_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : dff_stage
`default_nettype wire

// File: rtl/dff_sync.sv
`default_nettype none
// ============================================================================
// Module      : dff_sync
// Description : Edge-triggered D register, optionally a STAGES-deep delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_sync
    import dff_sync_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int STAGES  = DEF_STAGES,
    parameter     RST_VAL = DEF_RST_VAL
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dff_sync_if.slave  bus
);

    // w_chain[0] is the input; w_chain[i+1] is the output of stage i.
    logic [WIDTH-1:0] w_chain [STAGES+1];

    assign w_chain[0] = bus.D;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            dff_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (bus.en),
                .d   (w_chain[i]),
                .q   (w_chain[i+1])
            );
        end
    endgenerate

    assign bus.Q   = w_chain[STAGES];
    assign bus.Q_n = ~w_chain[STAGES];

endmodule : dff_sync
`default_nettype wire

// File: tb/tb_dff_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_sync
// Description : Self-checking bench for a 1-bit single-stage and an 8-bit
//               3-stage (reset value A5) dff_sync instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_sync;

    localparam logic [7:0] C_RST_B = 8'hA5;

    typedef struct {
        logic rst;
        logic en;
        logic d;
        logic exp_q;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_pass   = 0;

    dff_sync_if #(.WIDTH(1)) bus_a ();
    dff_sync_if #(.WIDTH(8)) bus_b ();

    dff_sync #(
        .WIDTH   (1),
        .STAGES  (1),
        .RST_VAL (0)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    dff_sync #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'hA5)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic exp_q);
        check({name, ".Q"},   {7'b0, bus_a.Q},   {7'b0, exp_q});
        check({name, ".Q_n"}, {7'b0, bus_a.Q_n}, {7'b0, ~exp_q});
    endtask

    task automatic check_b(input string name, input logic [7:0] exp_q);
        check({name, ".Q"},   bus_b.Q,   exp_q);
        check({name, ".Q_n"}, bus_b.Q_n, ~exp_q);
    endtask

    // Reference for the delay line: the value shown on Q is the one accepted
    // three loads ago; a reset refills the history with the reset value.
    logic [7:0] hist [$];

    task automatic model_reset();
        hist = {};
        repeat (3) hist.push_back(C_RST_B);
    endtask

    task automatic model_load(input logic [7:0] d);
        hist.push_back(d);
        void'(hist.pop_front());
    endtask

    vec_t vecs [13];

    initial begin
        vecs = '{
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1}
        };

        rst_a    = 1'b1;
        bus_a.en = 1'b1;
        bus_a.D  = 1'b0;
        rst_b    = 1'b1;
        bus_b.en = 1'b0;
        bus_b.D  = 8'h00;

        // Reset held while D wiggles: Q must stay at the reset value.
        for (int i = 0; i < 10; i++) begin
            bus_a.D = 1'(i % 2);
            tick();
            check_a($sformatf("rst_hold%0d", i), 1'b0);
        end

        for (int i = 0; i < 13; i++) begin
            rst_a    = vecs[i].rst;
            bus_a.en = vecs[i].en;
            bus_a.D  = vecs[i].d;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].exp_q);
        end

        // Glitches between edges ending on the already-stored value.
        rst_a    = 1'b0;
        bus_a.en = 1'b1;
        bus_a.D  = 1'b1;
        tick();
        check_a("glitch_pre", 1'b1);
        repeat (8) #2 bus_a.D = ~bus_a.D;
        check_a("glitch_mid1", 1'b1);
        tick();
        check_a("glitch_edge1", 1'b1);

        bus_a.D = 1'b0;
        tick();
        check_a("glitch_fall", 1'b0);
        repeat (8) #2 bus_a.D = ~bus_a.D;
        check_a("glitch_mid0", 1'b0);
        tick();
        check_a("glitch_edge0", 1'b0);

        // A reset pulse that misses the edge must have no effect.
        bus_a.D = 1'b1;
        tick();
        check_a("rst_pulse_pre", 1'b1);
        #4 rst_a = 1'b1;
        #4 rst_a = 1'b0;
        check_a("rst_pulse_mid", 1'b1);
        bus_a.D = 1'b0;
        tick();
        check_a("rst_pulse_edge", 1'b0);

        // Delay line: reset value, then 3-edge latency, then mid-shift reset.
        tick();
        check_b("b_reset", C_RST_B);
        model_reset();
        rst_b    = 1'b0;
        bus_b.en = 1'b1;
        bus_b.D  = 8'h01;
        tick();
        check_b("b_lat1", C_RST_B);
        bus_b.D = 8'h02;
        tick();
        check_b("b_lat2", C_RST_B);
        bus_b.D = 8'h03;
        tick();
        check_b("b_lat3", 8'h01);
        bus_b.D = 8'h04;
        tick();
        check_b("b_lat4", 8'h02);
        rst_b = 1'b1;
        tick();
        check_b("b_mid_rst", C_RST_B);
        bus_b.en = 1'b0;
        tick();
        check_b("b_rst_noen", C_RST_B);
        rst_b = 1'b0;
        bus_b.D = 8'h77;
        tick();
        check_b("b_hold_after_rst", C_RST_B);

        model_reset();
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       e;
            logic [7:0] d;
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            rst_b    = r;
            bus_b.en = e;
            bus_b.D  = d;
            tick();
            if (r) model_reset();
            else if (e) model_load(d);
            check_b($sformatf("b_rand%0d", i), hist[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dff_sync
`default_nettype wire
